// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP48A1 slice as a multiply-accumulate engine.
// Takes a job (length N, add/subtract), streams N operand pairs into the slice,
// times OPMODE/CEP against the slice pipeline latency LAT, and returns the
// 48-bit accumulated P on a result handshake.
// Optional feature: define DSP_SEQ_OVF_EN to build the sticky carry-out
// overflow flag; when undefined res_ovf is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a job, job_ready high
// S_RUN   | accepting operand pairs until the remaining count hits zero
// S_DRAIN | waiting for in-flight beats to land in P, then capturing P
// S_DONE  | result held on res_data until res_ready
module dsp_mac_sequencer #(
  parameter int LAT   = 4,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_sub,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_ovf
);

  // Beats take LAT-1 cycles from issue to the cycle that drives their OPMODE/CEP.
  localparam int PD = LAT - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             sub_q;
  logic             first_pending;
  logic             drain_armed;
  logic [PD-1:0]    pipe_vld;
  logic [PD-1:0]    pipe_first;
  logic             op_fire;
  logic             job_fire;
  logic             out_vld;
  logic             out_first;

  assign job_ready = (state == S_IDLE);
  assign op_ready  = (state == S_RUN) && (remaining != '0);
  assign res_valid = (state == S_DONE);
  assign op_fire   = op_valid & op_ready;
  assign job_fire  = job_valid & job_ready;
  assign out_vld   = pipe_vld[PD-1];
  assign out_first = pipe_first[PD-1];

  // Sequencer FSM, operand issue stage and control pipe with registered slice controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      remaining     <= '0;
      sub_q         <= 1'b0;
      first_pending <= 1'b0;
      drain_armed   <= 1'b0;
      pipe_vld      <= '0;
      pipe_first    <= '0;
      dsp_a         <= '0;
      dsp_b         <= '0;
      dsp_cea       <= 1'b0;
      dsp_ceb       <= 1'b0;
      dsp_cem       <= 1'b0;
      dsp_cep       <= 1'b0;
      dsp_rstp      <= 1'b1;
      dsp_opmode    <= 8'b0000_0000;
      res_data      <= '0;
    end else begin
      dsp_rstp <= 1'b0;
      dsp_cea  <= op_fire;
      dsp_ceb  <= op_fire;
      dsp_cem  <= op_fire;
      if (op_fire) begin
        dsp_a <= op_a;
        dsp_b <= op_b;
      end

      pipe_vld   <= PD'({pipe_vld, op_fire});
      pipe_first <= PD'({pipe_first, op_fire & first_pending});

      // First beat loads P = M, later beats accumulate onto P, bubbles hold P.
      dsp_cep <= out_vld;
      if (out_vld)
        dsp_opmode <= {sub_q, 3'b000, (out_first ? 4'b0001 : 4'b1001)};
      else
        dsp_opmode <= 8'b0000_1000;

      case (state)
        S_IDLE: begin
          if (job_fire) begin
            remaining     <= job_len;
            sub_q         <= job_sub;
            dsp_rstp      <= 1'b1;
            first_pending <= 1'b1;
            drain_armed   <= 1'b0;
            if (job_len == '0) begin
              res_data <= '0;
              state    <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (op_fire) begin
            remaining     <= remaining - LEN_W'(1);
            first_pending <= 1'b0;
            if (remaining == LEN_W'(1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // P reflects the last beat one cycle after the pipe has emptied.
          if (drain_armed) begin
            res_data    <= dsp_p;
            drain_armed <= 1'b0;
            state       <= S_DONE;
          end else if (pipe_vld == '0) begin
            drain_armed <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DSP_SEQ_OVF_EN
  logic ovf_chk;
  logic ovf_q;

  // Sticky carry-out: sampled the cycle after each accumulating (non-first) beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_chk <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_chk <= out_vld & ~out_first;
      if (job_fire)
        ovf_q <= 1'b0;
      else if (ovf_chk)
        ovf_q <= ovf_q | dsp_carryout;
    end
  end

  assign res_ovf = ovf_q;
`else
  logic unused_carryout;

  assign unused_carryout = dsp_carryout;
  assign res_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model
// (input register, product pipe, P register with X=M / Z=P / subtract decode).
module tb_dsp_mac_sequencer;
  localparam int LAT   = 4;
  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [LEN_W-1:0] job_len = '0;
  logic             job_sub = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [17:0]      op_a = '0;
  logic [17:0]      op_b = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstp;
  logic [7:0]       dsp_opmode;
  logic [47:0]      p_q;
  logic             dsp_carryout = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
  logic             res_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_sub(job_sub),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp), .dsp_opmode(dsp_opmode),
    .dsp_p(p_q), .dsp_carryout(dsp_carryout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  // Slice model: product enters on CEA/CEB, lands at the P register LAT-1 cycles later.
  logic [47:0] mpipe [0:LAT-2];
  logic [47:0] x_sel, z_sel;
  assign x_sel = (dsp_opmode[1:0] == 2'b01) ? mpipe[LAT-2] : 48'd0;
  assign z_sel = (dsp_opmode[3:2] == 2'b10) ? p_q : 48'd0;

  always @(posedge clk) begin
    mpipe[0] <= (dsp_cea && dsp_ceb) ? 48'($signed(dsp_a)) * 48'($signed(dsp_b)) : 48'd0;
    for (int k = 1; k < LAT - 1; k++) mpipe[k] <= mpipe[k-1];
    if (dsp_rstp) p_q <= 48'd0;
    else if (dsp_cep) p_q <= dsp_opmode[7] ? (z_sel - x_sel) : (z_sel + x_sel);
  end

  // Event monitor: cycle count, CEP pulses, last operand accept, res_valid rises.
  int   cyc = 0, cep_cnt = 0, rise_cnt = 0, last_acc = 0, rise_cyc = 0;
  logic rv_prev = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dsp_cep) cep_cnt <= cep_cnt + 1;
    if (op_valid && op_ready) last_acc <= cyc;
    if (res_valid && !rv_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    rv_prev <= res_valid;
  end

  logic signed [17:0] va [0:7];
  logic signed [17:0] vb [0:7];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input int n, input bit sub);
    @(negedge clk);
    job_valid = 1'b1;
    job_len   = LEN_W'(n);
    job_sub   = sub;
    for (int w = 0; w < 50 && !job_ready; w++) @(negedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic send_ops(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0;
      repeat (gap) @(negedge clk);
      op_a     = va[i];
      op_b     = vb[i];
      op_valid = 1'b1;
      for (int w = 0; w < 50 && !op_ready; w++) @(negedge clk);
      @(negedge clk);
    end
    op_valid = 1'b0;
  endtask

  task automatic get_res(output logic [47:0] d, output logic ovf, output int waited);
    waited = 0;
    while (!res_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    d   = res_data;
    ovf = res_ovf;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [47:0] d;
  logic        ovf;
  int          waited;
  int          cep_snap, rise_snap;
  logic        exp_ovf;

  initial begin
    // Reset state while rst_n is low.
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 48'(job_ready), 48'd1);
    chk("rst_op_ready", 48'(op_ready), 48'd0);
    chk("rst_res_valid", 48'(res_valid), 48'd0);
    chk("rst_res_data", res_data, 48'd0);
    chk("rst_res_ovf", 48'(res_ovf), 48'd0);
    chk("rst_rstp", 48'(dsp_rstp), 48'd1);
    chk("rst_opmode", 48'(dsp_opmode), 48'd0);
    chk("rst_ce", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep}), 48'd0);
    chk("rst_dsp_ab", 48'({dsp_a, dsp_b}), 48'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstp_release", 48'(dsp_rstp), 48'd0);

    // N=4 add: 1*2 + 3*4 + (-5)*6 + 7*8 = 2 + 12 - 30 + 56 = 40.
    va[0] = 18'sd1;  vb[0] = 18'sd2;
    va[1] = 18'sd3;  vb[1] = 18'sd4;
    va[2] = -18'sd5; vb[2] = 18'sd6;
    va[3] = 18'sd7;  vb[3] = 18'sd8;
    cep_snap = cep_cnt;
    send_job(4, 1'b0);
    send_ops(4, 0);
    get_res(d, ovf, waited);
    chk("add4_timeout", 48'(waited < 200), 48'd1);
    chk("add4_data", d, 48'd40);
    chk("add4_latency", 48'(rise_cyc - last_acc), 48'(LAT + 2));
    chk("add4_cep_count", 48'(cep_cnt - cep_snap), 48'd4);
    chk("add4_job_ready_after", 48'(job_ready), 48'd1);

    // Same pairs, subtract: -40.
    send_job(4, 1'b1);
    send_ops(4, 0);
    get_res(d, ovf, waited);
    chk("sub4_data", d, 48'hFFFF_FFFF_FFD8);
    chk("sub4_latency", 48'(rise_cyc - last_acc), 48'(LAT + 2));

    // N=3 with 5-cycle gaps: 2 + 12 - 30 = -16, same as without stalls.
    cep_snap = cep_cnt;
    send_job(3, 1'b0);
    send_ops(3, 5);
    get_res(d, ovf, waited);
    chk("stall3_data", d, 48'hFFFF_FFFF_FFF0);
    chk("stall3_cep_count", 48'(cep_cnt - cep_snap), 48'd3);

    // N=2 with carry-out forced high after the second pair.
    va[0] = 18'sd9;  vb[0] = 18'sd10;
    va[1] = 18'sd11; vb[1] = -18'sd2;
    send_job(2, 1'b0);
    send_ops(2, 0);
    dsp_carryout = 1'b1;
    get_res(d, ovf, waited);
    dsp_carryout = 1'b0;
`ifdef DSP_SEQ_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    chk("ovf2_data", d, 48'd68);
    chk("ovf2_flag", 48'(ovf), 48'(exp_ovf));

    // N=0: no CEP, zero result, ovf cleared, result almost immediately.
    cep_snap = cep_cnt;
    send_job(0, 1'b0);
    get_res(d, ovf, waited);
    chk("zero_data", d, 48'd0);
    chk("zero_ovf", 48'(ovf), 48'd0);
    chk("zero_wait", 48'(waited <= 2), 48'd1);
    chk("zero_cep_count", 48'(cep_cnt - cep_snap), 48'd0);

    // Reset mid-run of an N=8 job.
    for (int i = 0; i < 8; i++) begin
      va[i] = 18'(i + 1);
      vb[i] = 18'sd3;
    end
    send_job(8, 1'b0);
    send_ops(3, 0);
    rise_snap = rise_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_job_ready", 48'(job_ready), 48'd1);
    chk("midrst_op_ready", 48'(op_ready), 48'd0);
    chk("midrst_res_valid", 48'(res_valid), 48'd0);
    chk("midrst_rstp", 48'(dsp_rstp), 48'd1);
    chk("midrst_ctrl", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_opmode}), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_result", 48'(rise_cnt - rise_snap), 48'd0);
    chk("midrst_idle", 48'(job_ready), 48'd1);

    // Fresh N=2 job after reset: 2*3 + 4*5 = 26.
    va[0] = 18'sd2; vb[0] = 18'sd3;
    va[1] = 18'sd4; vb[1] = 18'sd5;
    send_job(2, 1'b0);
    send_ops(2, 0);
    get_res(d, ovf, waited);
    chk("post_rst_data", d, 48'd26);
    chk("post_rst_latency", 48'(rise_cyc - last_acc), 48'(LAT + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
